// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: phase flags, serve/point countdowns, scores and win detection.
// Optional pause support is compiled in with the PONG_PAUSE_EN macro.
module pong_match_ctrl #(
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned SCORE_W      = 4,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 30
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_clk,
  input  logic               start,
  input  logic               point_l,
  input  logic               point_r,
`ifdef PONG_PAUSE_EN
  input  logic               pause,
`endif
  output logic               nGame,
  output logic               eGame,
  output logic               resetB,
  output logic               run,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] scoreL,
  output logic [SCORE_W-1:0] scoreR,
  output logic               winner,
  output logic [7:0]         countdown
);

  localparam logic [SCORE_W-1:0] WinScore = SCORE_W'(WIN_SCORE);
  localparam logic [7:0]         ServeLd  = 8'(SERVE_FRAMES);
  localparam logic [7:0]         PointLd  = 8'(POINT_FRAMES);

  typedef enum logic [2:0] {StIdle, StServe, StPlay, StPoint, StOver, StPaused} state_e;

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d, score_r_q, score_r_d;
  logic               serve_dir_q, serve_dir_d, winner_q, winner_d;
  logic               frame_q, start_q;
  logic               tick, start_e, pause_e;
  logic [SCORE_W-1:0] score_l_inc, score_r_inc;

  assign tick        = frame_clk & ~frame_q;
  assign start_e     = start & ~start_q;
  assign score_l_inc = score_l_q + SCORE_W'(1);
  assign score_r_inc = score_r_q + SCORE_W'(1);

`ifdef PONG_PAUSE_EN
  logic pause_q;
  assign pause_e = pause & ~pause_q;

  always_ff @(posedge Clk) begin
    pause_q <= pause;
  end
`else
  assign pause_e = 1'b0;
`endif

  // Edge registers load the live input during reset so a held level is not an edge.
  always_ff @(posedge Clk) begin
    frame_q <= frame_clk;
    start_q <= start;
    if (!Reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      score_l_q   <= '0;
      score_r_q   <= '0;
      serve_dir_q <= 1'b0;
      winner_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      serve_dir_q <= serve_dir_d;
      winner_q    <= winner_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    serve_dir_d = serve_dir_q;
    winner_d    = winner_q;
    unique case (state_q)
      StIdle: begin
        if (start_e) begin
          state_d   = StServe;
          score_l_d = '0;
          score_r_d = '0;
          cnt_d     = ServeLd;
        end
      end
      StServe, StPoint: begin
        if (tick) begin
          if (cnt_q == 8'd1) begin
            state_d = (state_q == StServe) ? StPlay : StServe;
            cnt_d   = (state_q == StServe) ? 8'd0 : ServeLd;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      StPlay: begin
        // A simultaneous point pair is a tie and discarded; a real point beats pause.
        if (point_l && !point_r) begin
          score_l_d   = score_l_inc;
          serve_dir_d = 1'b1;
          if (score_l_inc == WinScore) begin
            state_d  = StOver;
            winner_d = 1'b0;
          end else begin
            state_d = StPoint;
            cnt_d   = PointLd;
          end
        end else if (point_r && !point_l) begin
          score_r_d   = score_r_inc;
          serve_dir_d = 1'b0;
          if (score_r_inc == WinScore) begin
            state_d  = StOver;
            winner_d = 1'b1;
          end else begin
            state_d = StPoint;
            cnt_d   = PointLd;
          end
        end else if (pause_e) begin
          state_d = StPaused;
        end
      end
      StPaused: begin
        if (pause_e) state_d = StPlay;
      end
      StOver: begin
        if (start_e) begin
          state_d     = StServe;
          score_l_d   = '0;
          score_r_d   = '0;
          serve_dir_d = 1'b0;
          cnt_d       = ServeLd;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    nGame     = (state_q == StIdle);
    eGame     = (state_q == StOver);
    run       = (state_q == StPlay);
    resetB    = (state_q == StIdle) || (state_q == StServe) ||
                (state_q == StPoint) || (state_q == StOver);
    countdown = ((state_q == StServe) || (state_q == StPoint)) ? cnt_q : 8'd0;
    serve_dir = serve_dir_q;
    scoreL    = score_l_q;
    scoreR    = score_r_q;
    winner    = winner_q;
  end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: directed scenarios with literal expectations, then random
// stimulus checked every cycle against a phase-level match model.
module tb_pong_match_ctrl;

  localparam int WIN = 3;
  localparam int SF  = 4;
  localparam int PF  = 2;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_clk = 1'b0, start = 1'b0, point_l = 1'b0, point_r = 1'b0, pause = 1'b0;
  logic       nGame, eGame, resetB, run, serve_dir, winner;
  logic [3:0] scoreL, scoreR;
  logic [7:0] countdown;

  pong_match_ctrl #(
    .WIN_SCORE   (WIN),
    .SCORE_W     (4),
    .SERVE_FRAMES(SF),
    .POINT_FRAMES(PF)
  ) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .frame_clk(frame_clk),
    .start    (start),
    .point_l  (point_l),
    .point_r  (point_r),
`ifdef PONG_PAUSE_EN
    .pause    (pause),
`endif
    .nGame    (nGame),
    .eGame    (eGame),
    .resetB   (resetB),
    .run      (run),
    .serve_dir(serve_dir),
    .scoreL   (scoreL),
    .scoreR   (scoreR),
    .winner   (winner),
    .countdown(countdown)
  );

  always #5 Clk = ~Clk;

  typedef enum {PhIdle, PhServe, PhPlay, PhPoint, PhOver, PhPaused} phase_e;

  phase_e m_ph = PhIdle;
  int     m_sl = 0, m_sr = 0, m_cnt = 0;
  bit     m_sd = 0, m_wn = 0;
  bit     m_pf = 0, m_ps = 0, m_pp = 0;
  bit     chk_on = 0;
  int     n_cmp = 0;
  int     n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, want %0h", nm, $time, act, exp);
    end
  endtask

  // Match rules applied once per clock to the inputs sampled at that edge.
  task automatic model_step();
    bit tk, se, pe;
    if (!Reset_n) begin
      m_ph = PhIdle; m_sl = 0; m_sr = 0; m_cnt = 0; m_sd = 0; m_wn = 0;
    end else begin
      tk = frame_clk && !m_pf;
      se = start && !m_ps;
`ifdef PONG_PAUSE_EN
      pe = pause && !m_pp;
`else
      pe = 0;
`endif
      if (m_ph == PhIdle) begin
        if (se) begin m_ph = PhServe; m_sl = 0; m_sr = 0; m_cnt = SF; end
      end else if (m_ph == PhServe) begin
        if (tk) begin
          m_cnt = m_cnt - 1;
          if (m_cnt == 0) m_ph = PhPlay;
        end
      end else if (m_ph == PhPoint) begin
        if (tk) begin
          m_cnt = m_cnt - 1;
          if (m_cnt == 0) begin m_ph = PhServe; m_cnt = SF; end
        end
      end else if (m_ph == PhPlay) begin
        if (point_l && !point_r) begin
          m_sl++; m_sd = 1;
          if (m_sl == WIN) begin m_ph = PhOver; m_wn = 0; end
          else begin m_ph = PhPoint; m_cnt = PF; end
        end else if (point_r && !point_l) begin
          m_sr++; m_sd = 0;
          if (m_sr == WIN) begin m_ph = PhOver; m_wn = 1; end
          else begin m_ph = PhPoint; m_cnt = PF; end
        end else if (pe) begin
          m_ph = PhPaused;
        end
      end else if (m_ph == PhPaused) begin
        if (pe) m_ph = PhPlay;
      end else begin
        if (se) begin m_ph = PhServe; m_sl = 0; m_sr = 0; m_sd = 0; m_cnt = SF; end
      end
    end
    m_pf = frame_clk; m_ps = start; m_pp = pause;
  endtask

  task automatic compare_all();
    bit cnt_vis;
    cnt_vis = (m_ph == PhServe) || (m_ph == PhPoint);
    chk("nGame", 32'(nGame), 32'(m_ph == PhIdle));
    chk("eGame", 32'(eGame), 32'(m_ph == PhOver));
    chk("run", 32'(run), 32'(m_ph == PhPlay));
    chk("resetB", 32'(resetB), 32'((m_ph != PhPlay) && (m_ph != PhPaused)));
    chk("serve_dir", 32'(serve_dir), 32'(m_sd));
    chk("scoreL", 32'(scoreL), 32'(m_sl));
    chk("scoreR", 32'(scoreR), 32'(m_sr));
    chk("winner", 32'(winner), 32'(m_wn));
    chk("countdown", 32'(countdown), cnt_vis ? 32'(m_cnt) : 32'd0);
  endtask

  task automatic cyc();
    @(posedge Clk);
    model_step();
    #1;
    if (chk_on) compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_clk = 1'b1; cyc();
      frame_clk = 1'b0; cyc();
    end
  endtask

  task automatic pulse_l();
    point_l = 1'b1; cyc(); point_l = 1'b0;
  endtask

  initial begin
    // Reset with start held high; a held level must not start a match.
    start = 1'b1;
    cyc(); chk_on = 1; cyc();
    Reset_n = 1'b1; cyc();
    chk("rst_nGame", 32'(nGame), 32'd1);
    chk("rst_resetB", 32'(resetB), 32'd1);
    chk("rst_run", 32'(run), 32'd0);
    chk("rst_scores", 32'({scoreL, scoreR}), 32'd0);
    cyc(); cyc();
    chk("held_start_idle", 32'(nGame), 32'd1);
    start = 1'b0; cyc();
    start = 1'b1; cyc();
    chk("serve_cd4", 32'(countdown), 32'd4);
    chk("serve_nGame", 32'(nGame), 32'd0);
    start = 1'b0;
    frame_clk = 1'b1; cyc(); chk("serve_cd3", 32'(countdown), 32'd3);
    frame_clk = 1'b0; cyc();
    ticks(2);
    chk("serve_cd1", 32'(countdown), 32'd1);
    frame_clk = 1'b1; cyc(); chk("play_run", 32'(run), 32'd1);
    frame_clk = 1'b0; cyc();

    point_r = 1'b1; cyc(); point_r = 1'b0;
    chk("pr_scoreR", 32'(scoreR), 32'd1);
    chk("pr_dir", 32'(serve_dir), 32'd0);
    chk("pr_resetB", 32'(resetB), 32'd1);
    chk("pr_cd", 32'(countdown), 32'd2);
    ticks(PF);
    chk("reserve_cd", 32'(countdown), 32'd4);
    ticks(SF);
    chk("replay_run", 32'(run), 32'd1);

    for (int i = 0; i < WIN; i++) begin
      pulse_l();
      if (i < WIN - 1) ticks(PF + SF);
    end
    chk("over_scoreL", 32'(scoreL), 32'd3);
    chk("over_eGame", 32'(eGame), 32'd1);
    chk("over_winner", 32'(winner), 32'd0);
    chk("over_run", 32'(run), 32'd0);
    pulse_l(); cyc();
    chk("over_hold", 32'(scoreL), 32'd3);
    start = 1'b1; cyc(); start = 1'b0;
    chk("restart_scores", 32'({scoreL, scoreR}), 32'd0);
    chk("restart_cd", 32'(countdown), 32'd4);
    chk("restart_dir", 32'(serve_dir), 32'd0);
    ticks(SF);

    point_l = 1'b1; point_r = 1'b1; cyc(); point_l = 1'b0; point_r = 1'b0;
    chk("tie_scores", 32'({scoreL, scoreR}), 32'd0);
    chk("tie_run", 32'(run), 32'd1);
    pulse_l(); ticks(PF);
    pulse_l(); cyc();
    chk("serve_ignore_pt", 32'(scoreL), 32'd1);
    ticks(SF);
    pulse_l();
    chk("mid_point_sl", 32'(scoreL), 32'd2);
    Reset_n = 1'b0; cyc(); Reset_n = 1'b1;
    chk("midrst_nGame", 32'(nGame), 32'd1);
    chk("midrst_scores", 32'({scoreL, scoreR}), 32'd0);
    chk("midrst_cd", 32'(countdown), 32'd0);

`ifdef PONG_PAUSE_EN
    start = 1'b1; cyc(); start = 1'b0; ticks(SF);
    pause = 1'b1; cyc(); pause = 1'b0;
    chk("pause_run", 32'(run), 32'd0);
    chk("pause_resetB", 32'(resetB), 32'd0);
    pulse_l(); cyc();
    chk("pause_ignore_pt", 32'(scoreL), 32'd0);
    pause = 1'b1; cyc(); pause = 1'b0;
    chk("resume_run", 32'(run), 32'd1);
`endif

    // Random play; the model judges every cycle.
    for (int i = 0; i < 6000; i++) begin
      Reset_n   = ($urandom_range(0, 799) != 0);
      frame_clk = ($urandom_range(0, 1) == 0) ? ~frame_clk : frame_clk;
      start     = ($urandom_range(0, 11) == 0);
      point_l   = ($urandom_range(0, 9) == 0);
      point_r   = ($urandom_range(0, 9) == 0);
      pause     = ($urandom_range(0, 5) == 0) ? ~pause : pause;
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
- Match sequencer for the Pong datapath; sits between the keycode/key PIO outputs and the ball, paddle and color blocks.
- Drives the game phase flags (nGame, eGame), the ball hold (resetB) and the motion enable (run).
- Owns both score counters, the serve direction and win detection.
- Paced by frame ticks derived from VGA_VS; runs entirely on the 50 MHz system clock.

Parameters:
- WIN_SCORE, 7, points needed to win the match; must satisfy 1 ≤ WIN_SCORE < 2^SCORE_W.
- SCORE_W, 4, width of each score output.
- SERVE_FRAMES, 60, frame ticks the ball is held at centre before play; range 1..255.
- POINT_FRAMES, 30, frame ticks of post-point freeze; range 1..255.

Ports:
- Clk  in  1  system clock (MAX10_CLK1_50 domain).
- Reset_n  in  1  synchronous, active-low reset.
- frame_clk  in  1  raw VGA_VS level, already in the Clk domain; rising edge = one frame tick.
- start  in  1  level; start/restart request.
- point_l  in  1  one-Clk pulse; left player scored.
- point_r  in  1  one-Clk pulse; right player scored.
- pause  in  1  level; pause toggle (present only with PONG_PAUSE_EN).
- nGame  out  1  high in IDLE (title screen).
- eGame  out  1  high in OVER (end screen).
- resetB  out  1  hold ball at centre; high in IDLE, SERVE, POINT and OVER.
- run  out  1  ball/paddle motion enable; high only in PLAY.
- serve_dir  out  1  0 = serve toward left, 1 = toward right.
- scoreL  out  SCORE_W  left score.
- scoreR  out  SCORE_W  right score.
- winner  out  1  0 = left, 1 = right; meaningful only in OVER.
- countdown  out  8  remaining frame ticks in SERVE/POINT; 0 otherwise.

Behaviour:
- All outputs registered; each responds one Clk after the input sample that causes the change.
- Reset (Reset_n = 0 at a Clk edge), from any state including mid-match:
  - state = IDLE, nGame = 1, resetB = 1.
  - eGame, run, serve_dir, winner, scores, countdown, internal counter = 0.
  - Edge-detect registers for frame_clk, start and pause load their current input values, so a level already high at reset release produces no edge.
- Edge detection:
  - tick = frame_clk & ~frame_clk_q.
  - start_e = start & ~start_q.
  - pause_e (macro only) = pause & ~pause_q.
- IDLE:
  - start_e → SERVE; scores cleared, counter = SERVE_FRAMES.
  - Points and ticks are ignored.
- SERVE:
  - Each tick decrements the counter.
  - A tick with counter == 1 → PLAY, counter = 0. PLAY is therefore entered exactly SERVE_FRAMES ticks after entry.
  - Points are ignored.
- PLAY, point_l alone:
  - scoreL + 1; serve_dir = 1 (serve toward the player who conceded).
  - If the new scoreL == WIN_SCORE → OVER with winner = 0.
  - Otherwise → POINT with counter = POINT_FRAMES.
- PLAY, point_r alone: mirror of point_l (scoreR + 1, serve_dir = 0, winner = 1).
- PLAY, point_l and point_r in the same cycle: both discarded (tie); state stays PLAY.
- POINT:
  - Each tick decrements the counter.
  - A tick with counter == 1 → SERVE with counter = SERVE_FRAMES.
  - Points are ignored.
- OVER:
  - Scores and winner hold.
  - start_e → SERVE: scores cleared, serve_dir = 0, counter = SERVE_FRAMES.
- Simultaneous start_e and tick on entry to SERVE: that tick is not counted.
- Scores never exceed WIN_SCORE; no wrap-around is possible.
- countdown mirrors the counter in SERVE/POINT and reads 0 in all other states.

Optional Feature:
- Macro: PONG_PAUSE_EN.
- When defined:
  - The pause port exists and a PAUSED state is added.
  - PLAY + pause_e → PAUSED: run = 0, resetB = 0 (ball frozen in place), points ignored, scores and counter frozen.
  - PAUSED + pause_e → PLAY.
  - In PLAY, a point and pause_e in the same cycle: the point is processed and pause_e is dropped.
  - pause_e in any state other than PLAY or PAUSED is ignored.
- When undefined: no pause port, no PAUSED state, identical behaviour otherwise.

Test Plan:
All scenarios use WIN_SCORE=3, SERVE_FRAMES=4, POINT_FRAMES=2.
1. Reset_n low for 2 Clk with start held high, then release → nGame=1, resetB=1, run=0, scores 0; no SERVE until start falls and rises again.
2. start pulse, then 4 frame_clk rising edges → state SERVE with countdown 4,3,2,1; run=1 one Clk after the 4th tick.
3. In PLAY, point_r pulse → scoreR=1, serve_dir=0, resetB=1, countdown=2; after 2 ticks back in SERVE with countdown=4; after 4 more ticks run=1.
4. Three point_l pulses, each in PLAY → scoreL=3, eGame=1, winner=0, run=0. A further point_l in OVER leaves scoreL=3. A start pulse clears scores and enters SERVE.
5. In PLAY, point_l and point_r in the same Clk → scores unchanged, run stays 1. Separately, a point_l during SERVE is ignored.
6. Assert Reset_n low mid-POINT with scoreL=2 → next Clk IDLE, all scores 0, countdown=0. With PONG_PAUSE_EN: a pause edge in PLAY gives run=0 and ignores point_l; a second pause edge gives run=1.
